// File: rtl/ldpc_parity_acc_pkg.sv
// Shared constants and types for the LDPC parity accumulator slice.
package ldpc_pkg;

    localparam int NSEG  = 27;   // row segments (one ROM each)
    localparam int SEG_W = 162;  // bits per segment
    localparam int NROWS = 19;   // generator rows per codeword

    // Row counter must be able to hold NROWS after the final increment.
    localparam int CNT_W     = $clog2(NROWS + 1);
    localparam int SEG_IDX_W = $clog2(NSEG);

    typedef logic [SEG_W-1:0] seg_t;
    typedef seg_t [NSEG-1:0]  row_t;
    typedef logic [NROWS-1:0] msg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ldpc_parity_acc_if.sv
// Message in, fetch-stage link and parity segment stream, bundled.
interface ldpc_parity_acc_if;
    import ldpc_pkg::*;

    msg_t msg_in;
    logic msg_valid;
    logic msg_ready;
    logic g_valid;
    row_t row_seg;
    logic row_valid;
    seg_t out_data;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic err_unexp;

    // Environment side: message source, fetch stage and parity sink.
    modport master (
        output msg_in, msg_valid, row_seg, row_valid, out_ready,
        input  msg_ready, g_valid, out_data, out_valid, out_last, err_unexp
    );

    // Accumulator side.
    modport slave (
        input  msg_in, msg_valid, row_seg, row_valid, out_ready,
        output msg_ready, g_valid, out_data, out_valid, out_last, err_unexp
    );

endinterface

// File: rtl/ldpc_seg_serializer.sv
// Walks the finished parity register out one segment per handshake.
module ldpc_seg_serializer
    import ldpc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic active,     // high for the whole DRAIN phase
    input  row_t acc,
    input  logic out_ready,
    output seg_t out_data,
    output logic out_valid,
    output logic out_last,
    output logic done        // last segment accepted this cycle
);

    logic [SEG_IDX_W-1:0] seg_idx;
    logic                 is_last;
    logic                 fire;

    assign is_last   = (seg_idx == SEG_IDX_W'(NSEG - 1));
    assign out_valid = active;
    assign out_last  = active && is_last;
    assign out_data  = acc[seg_idx];
    assign fire      = active && out_ready;
    assign done      = fire && is_last;

    // Segment index: advances only on accepted beats, parks at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_idx <= '0;
        end else if (!active) begin
            seg_idx <= '0;
        end else if (fire) begin
            seg_idx <= is_last ? '0 : seg_idx + SEG_IDX_W'(1);
        end
    end

endmodule

// File: rtl/ldpc_parity_acc.sv
// Requests 19 generator rows, XOR-accumulates the ones selected by the
// message bits, then streams the 27-segment parity out.
module ldpc_parity_acc
    import ldpc_pkg::*;
(
    input logic               clk,
    input logic               rst,
    ldpc_parity_acc_if.slave  bus
);

    state_t           state, state_nxt;
    msg_t             msg_q;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] row_cnt;
    logic             g_valid_q;
    logic             err_q;
    row_t             acc;

    logic accept;
    logic row_fire;
    logic row_sel;
    logic last_row;
    logic drain_done;
    seg_t ser_data;
    logic ser_valid;
    logic ser_last;

    assign accept   = (state == IDLE) && bus.msg_valid;
    assign row_fire = (state == RUN) && bus.row_valid;
    assign row_sel  = msg_q[row_cnt];
    assign last_row = row_fire && (row_cnt == CNT_W'(NROWS - 1));

    assign bus.msg_ready = (state == IDLE);
    assign bus.g_valid   = g_valid_q;
    assign bus.err_unexp = err_q;
    assign bus.out_data  = ser_data;
    assign bus.out_valid = ser_valid;
    assign bus.out_last  = ser_last;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: rows returned drive RUN->DRAIN, last handshake ends DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = RUN;
            RUN:     if (last_row)   state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Message latch, request burst and row counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            msg_q     <= '0;
            req_cnt   <= '0;
            row_cnt   <= '0;
            g_valid_q <= 1'b0;
        end else if (accept) begin
            msg_q     <= bus.msg_in;
            req_cnt   <= '0;
            row_cnt   <= '0;
            g_valid_q <= 1'b1;
        end else begin
            // Burst is exactly NROWS cycles; also cut it if RUN was left early.
            if (g_valid_q) begin
                if (state != RUN || req_cnt == CNT_W'(NROWS - 1))
                    g_valid_q <= 1'b0;
                else
                    req_cnt <= req_cnt + CNT_W'(1);
            end
            if (row_fire)
                row_cnt <= row_cnt + CNT_W'(1);
        end
    end

    // Sticky flag: a row showed up when no codeword was expecting one.
    always_ff @(posedge clk) begin
        if (!rst)                             err_q <= 1'b0;
        else if (bus.row_valid && state != RUN) err_q <= 1'b1;
    end

    // Per-segment GF(2) accumulators.
    for (genvar s = 0; s < NSEG; s++) begin : g_acc
        // Clear on accept, fold in the row when its message bit is set.
        always_ff @(posedge clk) begin
            if (!rst)
                acc[s] <= '0;
            else if (accept)
                acc[s] <= '0;
            else if (row_fire && row_sel)
                acc[s] <= acc[s] ^ bus.row_seg[s];
        end
    end

    ldpc_seg_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .active    (state == DRAIN),
        .acc       (acc),
        .out_ready (bus.out_ready),
        .out_data  (ser_data),
        .out_valid (ser_valid),
        .out_last  (ser_last),
        .done      (drain_done)
    );

endmodule

// File: tb/tb_ldpc_parity_acc.sv
// Scoreboard bench: ROM/fetch-stage model feeds the DUT, expected parity
// segments are queued at message time and checked as they stream out.
module tb_ldpc_parity_acc;
    import ldpc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ldpc_parity_acc_if ifc();

    ldpc_parity_acc dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        seg_t d;
        logic last;
    } exp_t;

    exp_t q[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   hs       = 0;
    int   last_cyc = -1;
    int   addr     = 0;
    logic stray    = 1'b0;

    task automatic chk(input string tag, input logic [SEG_W-1:0] act,
                       input logic [SEG_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Reference ROM contents: segment s (ROM s+1), address a.
    function automatic seg_t rom(input int s, input int a);
        logic [191:0] v;
        logic [31:0]  x;
        x = (32'(s) + 32'd1) * 32'h0100_0193 ^ (32'(a) + 32'd1) * 32'h9E37_79B9;
        for (int i = 0; i < 6; i++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
            v[i*32 +: 32] = x;
        end
        return v[SEG_W-1:0];
    endfunction

    function automatic seg_t exp_seg(input msg_t m, input int s);
        seg_t x = '0;
        for (int t = 0; t < NROWS; t++)
            if (m[t]) x = x ^ rom(s, t);
        return x;
    endfunction

    task automatic push_exp(input msg_t m);
        for (int s = 0; s < NSEG; s++)
            q.push_back('{d: exp_seg(m, s), last: (s == NSEG - 1)});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Fetch stage: one-cycle ROM, valid_H = g_valid delayed, address restarts per burst.
    always @(posedge clk) begin
        if (!rst) begin
            ifc.row_valid <= 1'b0;
            addr          <= 0;
        end else begin
            ifc.row_valid <= ifc.g_valid | stray;
            if (ifc.g_valid) begin
                for (int s = 0; s < NSEG; s++) ifc.row_seg[s] <= rom(s, addr);
                addr <= addr + 1;
            end else begin
                addr <= 0;
            end
        end
    end

    // Output monitor: every presented segment must match the queue head.
    always @(negedge clk) begin
        if (rst && ifc.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                chk("seg_data", ifc.out_data, q[0].d);
                chk("seg_last", ifc.out_last, q[0].last);
                if (ifc.out_ready) begin
                    if (q[0].last) begin
                        hs       = 0;
                        last_cyc = cyc;
                    end else begin
                        hs++;
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input msg_t m, input bit hold);
        int k = 0;
        push_exp(m);
        ifc.msg_in    = m;
        ifc.msg_valid = 1'b1;
        while (!ifc.msg_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept_wait", (k < 200), 1);
        @(posedge clk); #1;
        if (!hold) ifc.msg_valid = 1'b0;
    endtask

    task automatic wait_first_out();
        int k  = 0;
        int gv = 0;
        bit seen = 0;
        while (k < 60 && !seen) begin
            @(negedge clk);
            k++;
            gv += int'(ifc.g_valid);
            if (ifc.out_valid) seen = 1;
        end
        chk("first_out_lat", k, NROWS + 2);
        chk("g_valid_cycles", gv, NROWS);
    endtask

    task automatic wait_drain();
        int k  = 0;
        int gv = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
            gv += int'(ifc.g_valid);
        end
        chk("drain_done", q.size(), 0);
        chk("g_valid_in_drain", gv, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        msg_t msgs[5];
        msg_t ma;
        msg_t mb;
        int   k;
        int   rows;
        int   acc_cyc;
        bit   seen;

        msgs = '{19'h00000, 19'h00001, 19'h40000, 19'h7FFFF, 19'h2AAAA};
        ifc.msg_in    = '0;
        ifc.msg_valid = 1'b0;
        ifc.out_ready = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_msg_ready", ifc.msg_ready, 1);
        chk("rst_g_valid",   ifc.g_valid,   0);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_last",  ifc.out_last,  0);
        chk("rst_err",       ifc.err_unexp, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Plain codewords.
        foreach (msgs[i]) begin
            send(msgs[i], 0);
            wait_first_out();
            wait_drain();
        end

        // Backpressure at segment 3.
        send(19'h3C0F1, 0);
        wait_first_out();
        k = 0;
        while (hs != 3 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        ifc.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_hold", ifc.out_valid, 1);
        end
        chk("bp_no_pop", hs, 3);
        @(posedge clk); #1 ifc.out_ready = 1'b1;
        wait_drain();

        // Reset after 10 rows: abort, no partial output.
        send(19'h5A5A5, 0);
        rows = 0;
        k    = 0;
        while (rows < 10 && k < 100) begin
            @(negedge clk);
            k++;
            if (ifc.row_valid) rows++;
        end
        chk("rows_before_rst", rows, 10);
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_g_valid",   ifc.g_valid,   0);
        chk("abort_msg_ready", ifc.msg_ready, 1);
        chk("abort_out_valid", ifc.out_valid, 0);
        repeat (30) @(negedge clk);
        chk("abort_err", ifc.err_unexp, 0);
        @(posedge clk); #1;
        send(19'h0F0F3, 0);
        wait_first_out();
        wait_drain();

        // Stray row in IDLE.
        chk("err_before_stray", ifc.err_unexp, 0);
        stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        @(posedge clk); #1;
        chk("err_set", ifc.err_unexp, 1);
        send(19'h1F00F, 0);
        wait_first_out();
        wait_drain();
        chk("err_sticky", ifc.err_unexp, 1);

        // Back-to-back with msg_valid held.
        ma = 19'h13579;
        mb = 19'h6DB6D;
        send(ma, 1);
        ifc.msg_in = mb;
        push_exp(mb);
        wait_first_out();
        k       = 0;
        seen    = 0;
        acc_cyc = -1;
        while (k < 100 && !seen) begin
            @(negedge clk);
            k++;
            if (ifc.msg_ready) begin
                seen    = 1;
                acc_cyc = cyc;
                chk("b2b_gap", ifc.g_valid, 0);
            end
        end
        chk("b2b_accept_cyc", acc_cyc, last_cyc + 1);
        @(posedge clk); #1 ifc.msg_valid = 1'b0;
        wait_first_out();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ldpc_parity_acc.md
Name: ldpc_parity_acc

Overview:
- Downstream consumer of the generator-row fetch stage (27 ROM segments × 162 bits, addresses 0..18, one-cycle ROM latency, valid delayed one cycle as valid_H).
- Accepts a 19-bit message, drives the fetch stage's valid for exactly 19 cycles, and XOR-accumulates each returned G row gated by the matching message bit into a 4374-bit parity register.
- Streams the parity out as 27 segments of 162 bits under a valid/ready handshake.

Parameters:
- NSEG, 27, number of row segments (ROMs).
- SEG_W, 162, bits per segment.
- NROWS, 19, rows per codeword; ROM address range 0..NROWS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- msg_in  in  NROWS  message bits; bit t pairs with ROM address t.
- msg_valid  in  1  message offered.
- msg_ready  out  1  block can accept a message.
- g_valid  out  1  drives the fetch stage's valid input.
- row_seg  in  NSEG×SEG_W  fetch stage segment outputs; index s = ROM s+1.
- row_valid  in  1  fetch stage valid_H.
- out_data  out  SEG_W  current parity segment.
- out_valid  out  1  segment valid.
- out_ready  in  1  downstream accepts segment.
- out_last  out  1  high with segment NSEG-1.
- err_unexp  out  1  sticky: row_valid seen outside RUN, or more than NROWS rows in one codeword.

Behaviour:
- Reset (rst=0 at posedge): state IDLE, msg_ready=1, g_valid=0, out_valid=0, out_last=0, err_unexp=0, all counters 0, acc=0, msg register=0. Reset mid-RUN or mid-DRAIN aborts immediately. g_valid is 0 from the next cycle. No partial output is emitted.
- States:
  - IDLE: msg_ready=1. On msg_valid&msg_ready: latch msg_in, clear acc, req_cnt=0, row_cnt=0, go to RUN.
  - RUN: msg_ready=0. g_valid is registered and high for exactly NROWS consecutive cycles, starting the cycle after accept. req_cnt counts 0..NROWS-1 and g_valid drops after the last request. On each row_valid: acc[s] ^= msg[row_cnt] ? row_seg[s] : 0 for all s, and row_cnt++. When row_valid arrives with row_cnt==NROWS-1, go to DRAIN with seg_idx=0.
  - DRAIN: out_valid=1, out_data=acc[seg_idx], out_last=(seg_idx==NSEG-1). On out_valid&out_ready: seg_idx++. If last, go to IDLE.
- out_data, out_last and out_valid hold stable while out_ready=0.
- Latency: accept at edge T. g_valid high in cycles T+1..T+NROWS. row_valid expected in T+2..T+NROWS+1. out_valid first high at T+NROWS+2.
- g_valid returns low for at least one cycle between codewords. The fetch-stage address restarts at 0 on each burst.
- row_valid in IDLE or DRAIN: ignored for data, sets err_unexp.
- Rows are counted by row_valid, not by a cycle timer. Gaps in row_valid stall accumulation without error.
- msg_valid during RUN or DRAIN: not accepted. The source holds it.
- All arithmetic is GF(2) XOR. No width growth. Counters wrap only under reset.

Decomposition:
- Shared package ldpc_pkg holds:
  - constants NSEG, SEG_W, NROWS;
  - typedef seg_t (SEG_W bits);
  - typedef row_t (seg_t array [NSEG]);
  - enum state_t {IDLE, RUN, DRAIN};
  - clog2-derived counter widths.
- One natural sub-module: ldpc_seg_serializer. It covers the DRAIN-side seg_idx counter, output mux and valid/ready/last logic. Accumulation and FSM stay in the top module.

Test Plan:
- msg_in=19'h00000, rows from reference ROM model → 27 segments all zero, out_last only on the 27th, g_valid high exactly 19 cycles.
- msg_in=19'h00001 → segments equal ROM row 0 contents (rom1..rom27, address 0). msg_in=19'h40000 → equal row 18.
- msg_in=19'h7FFFF and 19'h2AAAA → segments match golden XOR of the selected rows. First out_valid occurs exactly NROWS+2 cycles after accept.
- Backpressure: out_ready=0 for 5 cycles at seg_idx=3 → out_data=acc[3] and out_valid held, then segments 4..26 follow in order, none lost or duplicated.
- Reset pulse (rst=0 one cycle) after 10 rows received → next cycle g_valid=0 and msg_ready=1, no out_valid. A following message encodes correctly.
- Back-to-back messages with msg_valid held: second accept only the cycle after the out_last handshake, with a g_valid gap ≥1 cycle. A stray row_valid injected in IDLE → err_unexp=1 sticky and data unaffected.
